// File: rtl/fish_round_sched_if.sv
// Bundle of the job-in, datapath and result ports of the fish round scheduler.
// slave is the scheduler's view; master is the controller/datapath side.
interface fish_round_sched_if;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] in_state;
  logic          abort;
  logic          busy;
  logic [7:0]    round_d;
  logic [1023:0] round_v;
  logic [5:0]    sk_idx;
  logic [1023:0] rnd_out;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] out_state;

  modport slave (
    input  in_valid, in_state, abort, rnd_out, out_ready,
    output in_ready, busy, round_d, round_v, sk_idx, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, abort, rnd_out, out_ready,
    input  in_ready, busy, round_d, round_v, sk_idx, out_valid, out_state
  );
endinterface

// File: rtl/fish_round_sched.sv
// Iterative round scheduler: feeds one 1024-bit state through NUM_ROUNDS passes
// of an external round datapath with ROUND_LAT cycles of latency per pass.
module fish_round_sched #(
  parameter int NUM_ROUNDS = 80,
  parameter int ROUND_LAT  = 1,
  parameter int SK_EVERY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  fish_round_sched_if.slave bus
);
  localparam int         SK_SH  = $clog2(SK_EVERY);
  localparam logic [7:0] LAST_D = 8'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAT    = 4'(ROUND_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [1023:0] v_reg, v_nx;
  logic [7:0]    d_reg, d_nx;
  logic [3:0]    wcnt, wcnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      v_reg <= '0;
      d_reg <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      v_reg <= v_nx;
      d_reg <= d_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    v_nx     = v_reg;
    d_nx     = d_reg;
    wcnt_nx  = wcnt;
    case (state)
      IDLE: if (bus.in_valid) begin
        v_nx     = bus.in_state;
        d_nx     = '0;
        wcnt_nx  = '0;
        state_nx = RUN;
      end
      RUN: begin
        // abort beats a same-edge capture, so the round result is dropped
        if (bus.abort) begin
          state_nx = IDLE;
          d_nx     = '0;
          wcnt_nx  = '0;
        end else if (wcnt == LAT) begin
          v_nx    = bus.rnd_out;
          wcnt_nx = '0;
          if (d_reg == LAST_D) state_nx = DONE;
          else                 d_nx     = d_reg + 8'd1;
        end else begin
          wcnt_nx = wcnt + 4'd1;
        end
      end
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.round_d   = d_reg;
  assign bus.round_v   = v_reg;
  assign bus.out_state = v_reg;
  assign bus.sk_idx    = 6'(d_reg >> SK_SH);

  // datapath inputs must not move inside a round's hold window
  assert property (@(posedge clk) disable iff (rst)
    (state == RUN && wcnt != 4'd0) |-> ($stable(d_reg) && $stable(v_reg)));
  assert property (@(posedge clk) disable iff (rst)
    (state == DONE && $past(state) == DONE) |-> $stable(v_reg));
endmodule

// File: tb/tb_fish_round_sched.sv
// Bench for fish_round_sched: four parameterisations side by side, a closed-form
// reference model checked every cycle, plus directed literal expectations.
module tb_fish_round_sched;
  localparam int NI = 4;
  localparam int NR [NI] = '{4, 80, 1, 256};
  localparam int LT [NI] = '{1, 0, 15, 0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iv [NI], ab [NI], ordy [NI];
  logic [1023:0] ist [NI];
  logic          irdy [NI], ovld [NI], bsy [NI];
  logic [7:0]    rd [NI];
  logic [5:0]    sk [NI];
  logic [1023:0] rv [NI], ost [NI];

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int N = NR[g];
    localparam int L = LT[g];
    fish_round_sched_if bus();
    fish_round_sched #(.NUM_ROUNDS(N), .ROUND_LAT(L), .SK_EVERY(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign bus.in_valid  = iv[g];
    assign bus.in_state  = ist[g];
    assign bus.abort     = ab[g];
    assign bus.out_ready = ordy[g];
    assign irdy[g] = bus.in_ready;
    assign ovld[g] = bus.out_valid;
    assign bsy[g]  = bus.busy;
    assign rd[g]   = bus.round_d;
    assign sk[g]   = bus.sk_idx;
    assign rv[g]   = bus.round_v;
    assign ost[g]  = bus.out_state;

    // datapath stub: state + round + 1, delayed by L register stages
    logic [1023:0] f;
    assign f = bus.round_v + {1016'b0, bus.round_d} + 1024'd1;
    if (L == 0) begin : comb_dp
      assign bus.rnd_out = f;
    end else begin : pipe_dp
      logic [1023:0] p [L];
      always @(posedge clk) begin
        p[0] <= f;
        for (int i = 1; i < L; i++) p[i] <= p[i-1];
      end
      assign bus.rnd_out = p[L-1];
    end
  end

  function automatic logic [1023:0] tri_sum(int r);
    return 1024'(r * (r + 1) / 2);
  endfunction

  // Reference model: mode 0 idle, 1 run, 2 done; k = cycles since accept.
  // After k run cycles, k/(L+1) rounds are complete and the state equals
  // base + sum_{j<r}(j+1).
  int            m_mode [NI], m_k [NI];
  logic [7:0]    m_d [NI];
  logic [1023:0] m_v [NI], m_base [NI];
  bit            armed = 1'b0;

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        m_mode[g] <= 0; m_k[g] <= 0; m_d[g] <= '0; m_v[g] <= '0;
      end else begin
        case (m_mode[g])
          0: if (iv[g]) begin
            m_mode[g] <= 1; m_k[g] <= 0; m_d[g] <= '0;
            m_base[g] <= ist[g]; m_v[g] <= ist[g];
          end
          1: if (ab[g]) begin
            m_mode[g] <= 0; m_d[g] <= '0;
          end else if (m_k[g] + 1 == NR[g] * (LT[g] + 1)) begin
            m_mode[g] <= 2; m_k[g] <= m_k[g] + 1;
            m_d[g] <= 8'(NR[g] - 1);
            m_v[g] <= m_base[g] + tri_sum(NR[g]);
          end else begin
            m_k[g] <= m_k[g] + 1;
            m_d[g] <= 8'((m_k[g] + 1) / (LT[g] + 1));
            m_v[g] <= m_base[g] + tri_sum((m_k[g] + 1) / (LT[g] + 1));
          end
          default: if (ordy[g]) m_mode[g] <= 0;
        endcase
      end
    end
  end

  int nchk = 0;
  int nfail = 0;

  task automatic chk1(string nm, logic act, logic exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%b want=%b @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(string nm, logic [1023:0] act, logic [1023:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h (low 64 bits) @%0t", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] rd_hist;
  int          sk_changes, rd_max;

  // Accept one job on instance g and wait (bounded) for out_valid.
  task automatic run_job(int g, logic [1023:0] s, int exp_lat, logic [1023:0] exp_out, string nm);
    int n;
    logic [5:0] sk_prev;
    iv[g] = 1'b1; ist[g] = s;
    tick();
    iv[g] = 1'b0;
    n = 0; rd_hist = '0; sk_changes = 0; rd_max = 0; sk_prev = sk[g];
    while (!ovld[g] && n < 400) begin
      rd_hist = {rd_hist[55:0], rd[g]};
      if (sk[g] != sk_prev) sk_changes++;
      sk_prev = sk[g];
      if (int'(rd[g]) > rd_max) rd_max = int'(rd[g]);
      tick();
      n++;
    end
    chki({nm, "_latency"}, n, exp_lat);
    chkv({nm, "_out_state"}, ost[g], exp_out);
  endtask

  task automatic handshake(int g, string nm);
    ordy[g] = 1'b1;
    tick();
    ordy[g] = 1'b0;
    chk1({nm, "_in_ready_after_hs"}, irdy[g], 1'b1);
    chk1({nm, "_out_valid_after_hs"}, ovld[g], 1'b0);
  endtask

  task automatic reset_checks(string nm);
    chk1({nm, "_in_ready"}, irdy[0], 1'b1);
    chk1({nm, "_out_valid"}, ovld[0], 1'b0);
    chk1({nm, "_busy"}, bsy[0], 1'b0);
    chkv({nm, "_round_v"}, rv[0], 1024'd0);
    chki({nm, "_round_d"}, int'(rd[0]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; ab[g] = 1'b0; ordy[g] = 1'b0; ist[g] = '0;
    end

    fork
      forever begin
        @(negedge clk);
        if (armed) begin
          for (int g = 0; g < NI; g++) begin
            chk1($sformatf("m%0d_in_ready", g), irdy[g], m_mode[g] == 0);
            chk1($sformatf("m%0d_busy", g), bsy[g], m_mode[g] != 0);
            chk1($sformatf("m%0d_out_valid", g), ovld[g], m_mode[g] == 2);
            chki($sformatf("m%0d_round_d", g), int'(rd[g]), int'(m_d[g]));
            chki($sformatf("m%0d_sk_idx", g), int'(sk[g]), int'(m_d[g]) / 4);
            chkv($sformatf("m%0d_round_v", g), rv[g], m_v[g]);
            chkv($sformatf("m%0d_out_state", g), ost[g], m_v[g]);
          end
        end
      end
    join_none

    tick(); tick();
    rst = 1'b0;
    reset_checks("por");
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chk1("abort_idle_ignored", irdy[0], 1'b1);

    // NUM_ROUNDS=4, ROUND_LAT=1, in_state=0
    run_job(0, 1024'd0, 8, 1024'd10, "a_job");
    chkv("a_round_d_seq", {960'b0, rd_hist}, {960'b0, 64'h0000_0101_0202_0303});
    chki("a_sk_changes", sk_changes, 0);
    for (int i = 0; i < 10; i++) begin
      ab[0] = (i == 3);
      chk1("bp_out_valid", ovld[0], 1'b1);
      chkv("bp_out_state", ost[0], 1024'd10);
      chk1("bp_in_ready", irdy[0], 1'b0);
      tick();
    end
    ab[0] = 1'b0;
    handshake(0, "a");

    // ROUND_LAT=0, NUM_ROUNDS=80, in_state=5
    run_job(1, 1024'd5, 80, 1024'd3245, "b_job");
    chki("b_sk_changes", sk_changes, 19);
    chki("b_sk_last", int'(sk[1]), 19);
    handshake(1, "b");

    // abort on the round-2 capture edge (6th edge after accept)
    iv[0] = 1'b1; ist[0] = '0;
    tick();
    iv[0] = 1'b0;
    repeat (5) tick();
    chki("ab_round_before", int'(rd[0]), 2);
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chk1("ab_in_ready", irdy[0], 1'b1);
    chk1("ab_out_valid", ovld[0], 1'b0);
    chki("ab_round_d", int'(rd[0]), 0);
    chkv("ab_v_not_captured", rv[0], 1024'd3);
    repeat (3) tick();
    run_job(0, 1024'd0, 8, 1024'd10, "a2_job");
    handshake(0, "a2");

    // reset mid-RUN with in_valid held during reset
    iv[0] = 1'b1; ist[0] = '0;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    chki("rst_run_round", int'(rd[0]), 1);
    rst = 1'b1; iv[0] = 1'b1; ist[0] = 1024'd99;
    tick();
    rst = 1'b0; iv[0] = 1'b0;
    reset_checks("rst_run");
    tick();
    chk1("rst_in_valid_dropped", bsy[0], 1'b0);

    // reset in DONE
    run_job(0, 1024'd0, 8, 1024'd10, "a3_job");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_checks("rst_done");
    chkv("rst_done_out_state", ost[0], 1024'd0);

    // NUM_ROUNDS=1, ROUND_LAT=15, in_state=7
    run_job(2, 1024'd7, 16, 1024'd8, "c_job");
    handshake(2, "c");

    // NUM_ROUNDS=256: d_reg reaches 255 without wrapping
    run_job(3, 1024'd0, 256, 1024'd32896, "d_job");
    chki("d_round_max", rd_max, 255);
    chki("d_round_done", int'(rd[3]), 255);
    handshake(3, "d");

    repeat (3) tick();
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
